// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC controller with return stack and run-cycle counter; ports clk/rst_n, start/stall, br_taken/br_target, jsr/sub_idx, ret, halt -> pc, running, done, fault, cycle_count; optional SEQ_STACK_CHECK_EN adds stack fault checking
module fetch_sequencer #(
  parameter int PC_W        = 10,
  parameter int STACK_DEPTH = 4,
  parameter int SUB_BASE    = 100,
  parameter int SUB_STRIDE  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [7:0]      br_target,
  input  logic            jsr,
  input  logic [3:0]      sub_idx,
  input  logic            ret,
  input  logic            halt,
  output logic [PC_W-1:0] pc,
  output logic            running,
  output logic            done,
  output logic            fault,
  output logic [15:0]     cycle_count
);
  localparam int AW = $clog2(STACK_DEPTH);
`ifdef SEQ_STACK_CHECK_EN
  localparam int SW = AW + 1;
`else
  localparam int SW = AW;
`endif
  typedef enum logic [1:0] {IDLE, RUN, HALT, FAULT} state_t;
  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc, sub_addr, ret_addr;
  logic [SW-1:0]   sp_q, sp_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [PC_W-1:0] stack_q [STACK_DEPTH];
  logic            push;
  assign pc_inc   = pc_q + PC_W'(1);
  assign sub_addr = PC_W'(SUB_BASE + int'(sub_idx) * SUB_STRIDE);
  // sp points at the next free slot, so the top entry sits one below it
  assign ret_addr = stack_q[AW'(sp_q - SW'(1))];
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    if (start) begin
      state_d = RUN;
      pc_d    = '0;
      sp_d    = '0;
      cnt_d   = '0;
    end else if (state_q == RUN && !stall) begin
      cnt_d = &cnt_q ? cnt_q : cnt_q + 16'd1;
      if (halt) state_d = HALT;
      else if (ret) begin
`ifdef SEQ_STACK_CHECK_EN
        if (sp_q == '0) state_d = FAULT;
        else begin
          pc_d = ret_addr;
          sp_d = sp_q - SW'(1);
        end
`else
        pc_d = ret_addr;
        sp_d = sp_q - SW'(1);
`endif
      end else if (jsr) begin
`ifdef SEQ_STACK_CHECK_EN
        if (sp_q == SW'(STACK_DEPTH)) state_d = FAULT;
        else begin
          push = 1'b1;
          pc_d = sub_addr;
          sp_d = sp_q + SW'(1);
        end
`else
        push = 1'b1;
        pc_d = sub_addr;
        sp_d = sp_q + SW'(1);
`endif
      end else if (br_taken) pc_d = {{(PC_W-8){1'b0}}, br_target};
      else pc_d = pc_inc;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      sp_q    <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
      if (push) stack_q[AW'(sp_q)] <= pc_inc;
    end
  end
  assign pc          = pc_q;
  assign cycle_count = cnt_q;
  assign running     = state_q == RUN;
  assign done        = state_q == HALT;
`ifdef SEQ_STACK_CHECK_EN
  assign fault       = state_q == FAULT;
`else
  assign fault       = 1'b0;
`endif
endmodule
